// File: rtl/arrow_key_repeat_pkg.sv
// Shared constants for the arrow-key conditioning block: key indices,
// repeat FSM encoding and default timing for the 65 MHz pixel clock.
package arrow_key_repeat_pkg;

  localparam int KEY_DOWN  = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int NUM_KEYS  = 4;

  localparam int DEF_DEBOUNCE_CYCLES = 650000;
  localparam int DEF_REPEAT_DELAY    = 32500000;
  localparam int DEF_REPEAT_PERIOD   = 3250000;
  localparam int DEF_CNT_W           = 25;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  // One-hot of the highest-priority set key; lower index wins (down first).
  function automatic logic [NUM_KEYS-1:0] pick_key(input logic [NUM_KEYS-1:0] lvl);
    logic [NUM_KEYS-1:0] sel;
    sel = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (lvl[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/arrow_key_repeat_debounce.sv
// Two-flop synchroniser followed by a stability filter: the stable level only
// follows the synchronised input after DEBOUNCE_CYCLES consecutive differing cycles.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/arrow_key_repeat.sv
// Turns four raw arrow buttons into single-cycle step pulses with auto-repeat,
// at most one direction per cycle (priority down > up > left > right).
module arrow_key_repeat
  import arrow_key_repeat_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  output logic up,
  output logic down,
  output logic left,
  output logic right
);

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [NUM_KEYS-1:0] lvl;
  logic [NUM_KEYS-1:0] active;

  rep_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] key_q, key_d;
  logic [NUM_KEYS-1:0] pulse_q, pulse_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_down (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_down), .level(lvl[KEY_DOWN])
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_up (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_up), .level(lvl[KEY_UP])
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_left (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_left), .level(lvl[KEY_LEFT])
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_right (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_right), .level(lvl[KEY_RIGHT])
  );

  assign active = pick_key(lvl);

  // key_q remembers which key was last pulsed so a change of winner while
  // held restarts the repeat sequence as a fresh press.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    pulse_d = '0;
    if (!enable || (active == '0)) begin
      state_d = IDLE;
      cnt_d   = '0;
      key_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          pulse_d = active;
          key_d   = active;
          cnt_d   = '0;
          state_d = DELAY;
        end
        DELAY: begin
          if (active != key_q) begin
            pulse_d = active;
            key_d   = active;
            cnt_d   = '0;
          end else if (cnt_q == RD_LAST) begin
            pulse_d = active;
            cnt_d   = '0;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (active != key_q) begin
            pulse_d = active;
            key_d   = active;
            cnt_d   = '0;
            state_d = DELAY;
          end else if (cnt_q == RP_LAST) begin
            pulse_d = active;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          key_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      pulse_q <= pulse_d;
    end
  end

  assign down  = pulse_q[KEY_DOWN];
  assign up    = pulse_q[KEY_UP];
  assign left  = pulse_q[KEY_LEFT];
  assign right = pulse_q[KEY_RIGHT];

endmodule

// File: tb/tb_arrow_key_repeat.sv
// Directed bench for arrow_key_repeat with short timing constants; every cycle
// of each scenario is compared against a hand-built expected pulse pattern.
module tb_arrow_key_repeat;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int CW = 25;

  localparam logic [3:0] P_DOWN  = 4'b0001;
  localparam logic [3:0] P_UP    = 4'b0010;
  localparam logic [3:0] P_LEFT  = 4'b0100;
  localparam logic [3:0] P_RIGHT = 4'b1000;

  logic clk = 1'b0;
  logic reset_n, enable;
  logic btn_up, btn_down, btn_left, btn_right;
  logic up, down, left, right;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  arrow_key_repeat #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .up(up), .down(down), .left(left), .right(right)
  );

  function automatic logic [3:0] outs();
    return {right, left, up, down};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(4'b0000);
  endtask

  task automatic add_pulse(input int cyc, input logic [3:0] v);
    exp_q[cyc-1] = v;
  endtask

  // Leaves the bench just after a clock edge; that edge is cycle 0.
  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b1;
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outs", 32'(outs()), 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic apply(input int scn, input int c);
    case (scn)
      1: btn_right = (c < 60);
      2: btn_up = (c < 3);
      3: begin
        btn_up   = 1'b1;
        btn_down = (c >= 15);
      end
      4: begin
        btn_left = 1'b1;
        if (c == 10) enable = 1'b0;
        if (c == 30) enable = 1'b1;
      end
      5: begin
        btn_down = 1'b1;
        if (c == 25) begin
          reset_n = 1'b0;
          #1;
          check_eq("t5_rst_async", 32'(outs()), 32'h0);
        end
        if (c == 27) reset_n = 1'b1;
      end
      6: btn_left = (c >= 12) ? 1'b1 : (((c / 2) % 2) == 0);
      default: ;
    endcase
  endtask

  task automatic run_scn(input int scn, input int n, input string tag);
    do_reset();
    for (int c = 0; c < n; c++) begin
      apply(scn, c);
      @(posedge clk);
      #1;
      check_eq($sformatf("%s_c%0d", tag, c + 1), 32'(outs()), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    // Right held: first pulse after debounce, then delay, then period.
    build_exp(60);
    add_pulse(7, P_RIGHT);
    for (int p = 27; p <= 57; p += 5) add_pulse(p, P_RIGHT);
    run_scn(1, 60, "t1");

    // Short glitch on up never becomes stable.
    build_exp(20);
    run_scn(2, 20, "t2");
    check_eq("t2_db_cnt", 32'(dut.u_deb_up.cnt_q), 32'h0);

    // Down overrides held up and restarts the delay.
    build_exp(45);
    add_pulse(7, P_UP);
    add_pulse(22, P_DOWN);
    add_pulse(42, P_DOWN);
    run_scn(3, 45, "t3");

    // Enable gating; re-enable with key held is a new press.
    build_exp(55);
    add_pulse(7, P_LEFT);
    add_pulse(31, P_LEFT);
    add_pulse(51, P_LEFT);
    run_scn(4, 55, "t4");

    // Reset mid-hold forces a full re-debounce.
    build_exp(40);
    add_pulse(7, P_DOWN);
    add_pulse(34, P_DOWN);
    run_scn(5, 40, "t5");

    // Bouncing left: one pulse 7 cycles after the final edge.
    build_exp(30);
    add_pulse(19, P_LEFT);
    run_scn(6, 30, "t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arrow_key_repeat.md
Name: arrow_key_repeat

Overview:
Conditions the four raw arrow push-buttons before they drive the corner-adjust stage. That stage moves a corner one pixel on every clock a direction is high. This block turns each press into a single-cycle step pulse, then auto-repeats at a human rate while the key is held. Each button is synchronised and debounced, and the result is priority-resolved to at most one direction per cycle.

Parameters:
DEBOUNCE_CYCLES, 650000, cycles a raw level must stay stable before it is accepted (10 ms at 65 MHz)
REPEAT_DELAY, 32500000, cycles from the first pulse to the first auto-repeat pulse (0.5 s)
REPEAT_PERIOD, 3250000, cycles between auto-repeat pulses (50 ms)
CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  pulses permitted (tied to the override switch)
btn_up  in  1  raw button, active-high, asynchronous
btn_down  in  1  raw button, active-high, asynchronous
btn_left  in  1  raw button, active-high, asynchronous
btn_right  in  1  raw button, active-high, asynchronous
up  out  1  single-cycle step pulse, registered
down  out  1  single-cycle step pulse, registered
left  out  1  single-cycle step pulse, registered
right  out  1  single-cycle step pulse, registered

Behaviour:
- Clocking and reset: one clock; reset is asynchronous, active-low.
- Reset values: all outputs 0, synchronisers 0, stable levels 0, counters 0, FSM in IDLE.
- Per-key debounce: 2-flop synchroniser, then counter.
  - Synchronised level equal to stable level: counter cleared.
  - Level differs: counter increments.
  - Counter reaches DEBOUNCE_CYCLES-1: stable level takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the stable level.
- Priority: active key = highest-priority stable key, down > up > left > right, or none. This matches the adjust stage's priority.
- Output rules: at most one output high in any cycle; every output is high for exactly one cycle per pulse event.
- FSM state IDLE (no active key):
  - Active key appears: pulse that key next cycle, clear the repeat counter, go to DELAY.
- FSM state DELAY:
  - Counter increments each cycle.
  - Counter reaches REPEAT_DELAY-1: pulse the active key, clear the counter, go to REPEAT.
- FSM state REPEAT:
  - Counter increments each cycle.
  - Counter reaches REPEAT_PERIOD-1: pulse the active key and clear the counter.
- Active key changes while held (DELAY or REPEAT), e.g. up held then down pressed: treat as a new press. Pulse the new key, clear the counter, go to DELAY.
- All keys released: go to IDLE immediately, no pulse.
- enable low:
  - FSM forced to IDLE, outputs 0.
  - Debouncers keep running.
  - When enable rises with a key already stable-high, this counts as a new press: pulse next cycle.
- Latency from a clean raw rising edge to the first pulse: DEBOUNCE_CYCLES+3 clocks (2 sync, DEBOUNCE_CYCLES filter, 1 output register).
  - Second pulse follows REPEAT_DELAY clocks after the first; each later pulse follows REPEAT_PERIOD clocks after the previous.
- Reset asserted mid-hold: outputs drop asynchronously. After release, a still-held key must re-debounce (DEBOUNCE_CYCLES+3) before pulsing.
- Counters saturate-free: each is cleared at its terminal count, so no wrap occurs.

Decomposition:
- Shared package holds:
  - key index constants KEY_DOWN=0, KEY_UP=1, KEY_LEFT=2, KEY_RIGHT=3;
  - FSM state encoding IDLE/DELAY/REPEAT;
  - default timing constants for the 65 MHz pixel clock.
- One sub-module, key_debounce (synchroniser plus filter counter, parameter DEBOUNCE_CYCLES), instantiated four times.
- Priority resolve, FSM and repeat counter live in the top.

Test Plan:
Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5 for all scenarios.
1. Press btn_right at cycle 0, hold 60 cycles -> right pulses at cycles 7, 27, 32, 37, ..., 57; no other output ever high.
2. btn_up high for 3 cycles, then low -> no pulse on any output; the debounce counter returns to 0.
3. Hold btn_up (first pulse at 7), press btn_down at cycle 15 -> down pulse at 22, next down at 42; no up pulse after 7.
4. Hold btn_left from cycle 0; drop enable at cycle 10 and raise it at cycle 30 -> left pulse at 7; none during 10-30; left pulse at 31, then at 51.
5. Hold btn_down; assert reset_n low at cycle 25 for 2 cycles -> outputs 0 immediately; next down pulse at 27+7=34.
6. Bouncing btn_left (toggling every 2 cycles for 12 cycles), then steady high -> exactly one left pulse, 7 cycles after the last toggle.
